// File: rtl/decoder_pkg.sv
// Shared decoder definitions: mode encodings and a generic one-hot helper.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest vector onehot() can produce; callers slice the low bits they need.
  localparam int ONEHOT_MAX = 256;

  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx,
                                                   input int unsigned width);
    logic [ONEHOT_MAX-1:0] v;
    v    = '0;
    v[0] = 1'b1;
    v    = v << idx;
    if (idx >= width) begin
      v = '0;
    end
    return v;
  endfunction

endpackage

// File: rtl/decoder_scan_tick_gen.sv
// Prescaler: pulses tick on the DIV-th consecutive running cycle.
// Latency: tick is combinational from the registered count and run.
// Backpressure: run low freezes the count; clr discards any partial count.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      if (tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Binary-to-one-hot decoder with registered index, enable and a prescaled auto-scan mode.
// Latency: one cycle from sel/en to y; scan steps every DIV cycles.
// Backpressure: hold freezes the scan index and prescaler; en low forces y inactive.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int DIV        = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 hold,
  output logic [(2**SEL_W)-1:0] y,
  output logic [SEL_W-1:0]     idx,
  output logic                 wrap
);

  localparam int N = 2 ** SEL_W;

  logic                  en_q;
  logic                  tick;
  logic                  clr;
  logic                  run;
  logic [ONEHOT_MAX-1:0] dec_full;
  logic [N-1:0]          dec;
  logic [N-1:0]          y_act;

  // Prescaler is discarded whenever we are not actively scanning.
  assign clr = ~en | (mode == MODE_DIRECT);
  assign run = (mode == MODE_SCAN) & ~hold;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .run   (run),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
      idx  <= '0;
      wrap <= 1'b0;
    end else begin
      en_q <= en;
      if (!en) begin
        idx  <= '0;
        wrap <= 1'b0;
      end else if (mode == MODE_DIRECT) begin
        idx  <= sel;
        wrap <= 1'b0;
      end else if (hold) begin
        wrap <= 1'b0;
      end else if (tick) begin
        idx  <= idx + 1'b1;
        wrap <= &idx;
      end else begin
        wrap <= 1'b0;
      end
    end
  end

  // Outputs decode only registered state, so nothing combinational reaches y from the inputs.
  always_comb begin
    dec_full = onehot(32'(idx), N);
    dec      = dec_full[N-1:0];
    y_act    = en_q ? dec : '0;
  end

  assign y = (ACTIVE_LOW != 0) ? ~y_act : y_act;

endmodule
